decode_stage: RTL and testbench

// - MIPS ID stage, directly upstream of regbank: takes fetched instr, drives regbank read addrs a1/a2,

---
 rtl/mips_pkg.sv | 66 ++++++
 rtl/decode_stage_if.sv | 45 ++++
 rtl/decode_stage_main_decoder.sv | 58 +++++
 rtl/decode_stage.sv | 160 ++++++++++++++++
 tb/tb_decode_stage.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS ID stage: opcode/funct codes, ALU
// control codes, the packed control bundle, the ID/EX register layout
// and the hazard FSM state type.
package mips_pkg;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic [2:0] alu_ctl;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = ctrl_t'(10'b0);

    typedef enum logic [0:0] {
        S_RUN     = 1'b0,
        S_LUSTALL = 1'b1
    } state_t;

    // Full contents of the ID/EX pipeline register
    typedef struct packed {
        logic               valid;
        ctrl_t              ctrl;
        logic [XLEN-1:0]    rs_data;
        logic [XLEN-1:0]    rt_data;
        logic [XLEN-1:0]    imm;
        logic [RADDR_W-1:0] rs;
        logic [RADDR_W-1:0] rt;
        logic [RADDR_W-1:0] dst;
        logic [XLEN-1:0]    pc4;
        logic [25:0]        jtarget;
    } idex_t;

    localparam idex_t IDEX_CLEAR = idex_t'(180'd0);

    function automatic logic [XLEN-1:0] sign_ext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Bus bundle for decode_stage: IF handshake, regbank read/writeback
// taps and the ID/EX outputs toward EX. master = surrounding pipeline,
// slave = decode_stage.
interface decode_stage_if;
    import mips_pkg::*;

    logic               if_valid;
    logic [XLEN-1:0]    if_instr;
    logic [XLEN-1:0]    if_pc4;
    logic               id_ready;
    logic [RADDR_W-1:0] rf_a1;
    logic [RADDR_W-1:0] rf_a2;
    logic [XLEN-1:0]    rf_rd1;
    logic [XLEN-1:0]    rf_rd2;
    logic               wb_we;
    logic [RADDR_W-1:0] wb_a3;
    logic [XLEN-1:0]    wb_wd;
    logic               ex_ready;
    logic               ex_flush;
    logic               ex_valid;
    ctrl_t              ex_ctrl;
    logic [XLEN-1:0]    ex_rs_data;
    logic [XLEN-1:0]    ex_rt_data;
    logic [XLEN-1:0]    ex_imm;
    logic [RADDR_W-1:0] ex_rs;
    logic [RADDR_W-1:0] ex_rt;
    logic [RADDR_W-1:0] ex_dst;
    logic [XLEN-1:0]    ex_pc4;
    logic [25:0]        ex_jtarget;

    modport master (
        output if_valid, if_instr, if_pc4, rf_rd1, rf_rd2,
               wb_we, wb_a3, wb_wd, ex_ready, ex_flush,
        input  id_ready, rf_a1, rf_a2, ex_valid, ex_ctrl, ex_rs_data,
               ex_rt_data, ex_imm, ex_rs, ex_rt, ex_dst, ex_pc4, ex_jtarget
    );

    modport slave (
        input  if_valid, if_instr, if_pc4, rf_rd1, rf_rd2,
               wb_we, wb_a3, wb_wd, ex_ready, ex_flush,
        output id_ready, rf_a1, rf_a2, ex_valid, ex_ctrl, ex_rs_data,
               ex_rt_data, ex_imm, ex_rs, ex_rt, ex_dst, ex_pc4, ex_jtarget
    );

endinterface

// File: rtl/decode_stage_main_decoder.sv
// main_decoder: combinational opcode/funct -> control bundle.
// Unknown opcodes or R-type functs produce illegal=1 with no side effects.
module main_decoder
    import mips_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output ctrl_t      ctrl
);

    // Map the instruction class to its control bundle
    always_comb begin
        ctrl = CTRL_NONE;
        case (op)
            OP_RTYPE: begin
                ctrl.reg_write = 1'b1;
                case (funct)
                    FN_ADD:  ctrl.alu_ctl = ALU_ADD;
                    FN_SUB:  ctrl.alu_ctl = ALU_SUB;
                    FN_AND:  ctrl.alu_ctl = ALU_AND;
                    FN_OR:   ctrl.alu_ctl = ALU_OR;
                    FN_SLT:  ctrl.alu_ctl = ALU_SLT;
                    default: begin
                        ctrl.reg_write = 1'b0;
                        ctrl.illegal   = 1'b1;
                    end
                endcase
            end
            OP_LW: begin
                ctrl.reg_write = 1'b1;
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_ctl   = ALU_ADD;
            end
            OP_SW: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_ctl   = ALU_ADD;
            end
            OP_BEQ: begin
                ctrl.branch  = 1'b1;
                ctrl.alu_ctl = ALU_SUB;
            end
            OP_ADDI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_ctl   = ALU_ADD;
            end
            OP_J: begin
                ctrl.jump = 1'b1;
            end
            default: begin
                ctrl.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: MIPS ID stage. Drives regbank read addresses, decodes
// the fetched instruction and registers it into ID/EX with load-use
// bubble insertion, EX backpressure and EX flush.
// Optional: define DECODE_WB_BYPASS_EN to forward the WB write data
// onto the operands when WB targets the register being read.
module decode_stage
    import mips_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    decode_stage_if.slave  bus
);

    logic [5:0]         op_s;
    logic [5:0]         funct_s;
    logic [RADDR_W-1:0] rs_s;
    logic [RADDR_W-1:0] rt_s;
    logic [RADDR_W-1:0] rd_s;
    logic [RADDR_W-1:0] dst_raw_s;
    logic [RADDR_W-1:0] dst_s;
    ctrl_t              ctrl_dec_s;
    ctrl_t              ctrl_s;
    logic [XLEN-1:0]    opa_s;
    logic [XLEN-1:0]    opb_s;
    logic               hold_s;
    logic               lu_haz_s;
    idex_t              idex_d;
    idex_t              idex_q;
    state_t             state_d;
    state_t             state_q;

    assign op_s    = bus.if_instr[31:26];
    assign rs_s    = bus.if_instr[25:21];
    assign rt_s    = bus.if_instr[20:16];
    assign rd_s    = bus.if_instr[15:11];
    assign funct_s = bus.if_instr[5:0];

    assign bus.rf_a1 = rs_s;
    assign bus.rf_a2 = rt_s;

    main_decoder u_main_decoder (
        .op    (op_s),
        .funct (funct_s),
        .ctrl  (ctrl_dec_s)
    );

    // Pick the destination and suppress writes aimed at $0
    always_comb begin
        ctrl_s = ctrl_dec_s;
        if (op_s == OP_RTYPE) begin
            dst_raw_s = rd_s;
        end else begin
            dst_raw_s = rt_s;
        end
        if (ctrl_dec_s.reg_write && (dst_raw_s != 5'd0)) begin
            ctrl_s.reg_write = 1'b1;
            dst_s            = dst_raw_s;
        end else begin
            ctrl_s.reg_write = 1'b0;
            dst_s            = 5'd0;
        end
    end

`ifdef DECODE_WB_BYPASS_EN
    // Forward WB data when the regbank read would miss this cycle's write
    always_comb begin
        if (bus.wb_we && (bus.wb_a3 != 5'd0) && (bus.wb_a3 == rs_s)) begin
            opa_s = bus.wb_wd;
        end else begin
            opa_s = bus.rf_rd1;
        end
        if (bus.wb_we && (bus.wb_a3 != 5'd0) && (bus.wb_a3 == rt_s)) begin
            opb_s = bus.wb_wd;
        end else begin
            opb_s = bus.rf_rd2;
        end
    end
`else
    // Regbank provides write-before-read, so operands pass straight through
    always_comb begin
        opa_s = bus.rf_rd1;
        opb_s = bus.rf_rd2;
    end

    logic bypass_unused_s;
    assign bypass_unused_s = ^{bus.wb_we, bus.wb_a3, bus.wb_wd};
`endif

    // Backpressure and load-use detection (rt compared for every opcode)
    always_comb begin
        hold_s   = idex_q.valid & ~bus.ex_ready;
        lu_haz_s = idex_q.valid & idex_q.ctrl.mem_read & (idex_q.dst != 5'd0) &
                   ((idex_q.dst == rs_s) | (idex_q.dst == rt_s));
        bus.id_ready = ~rst & ~hold_s & ~lu_haz_s;
    end

    // ID/EX next contents: flush > hold > bubble > load > drain
    always_comb begin
        idex_d = idex_q;
        if (bus.ex_flush) begin
            idex_d.valid = 1'b0;
        end else if (hold_s) begin
            idex_d = idex_q;
        end else if (lu_haz_s) begin
            idex_d.valid = 1'b0;
        end else if (bus.if_valid) begin
            idex_d.valid   = 1'b1;
            idex_d.ctrl    = ctrl_s;
            idex_d.rs_data = opa_s;
            idex_d.rt_data = opb_s;
            idex_d.imm     = sign_ext16(bus.if_instr[15:0]);
            idex_d.rs      = rs_s;
            idex_d.rt      = rt_s;
            idex_d.dst     = dst_s;
            idex_d.pc4     = bus.if_pc4;
            idex_d.jtarget = bus.if_instr[25:0];
        end else begin
            idex_d.valid = 1'b0;
        end
    end

    // Diagnostic stall tracker: marks the cycle after a bubble is inserted
    always_comb begin
        state_d = S_RUN;
        case (state_q)
            S_RUN: begin
                if (!bus.ex_flush && !hold_s && lu_haz_s) begin
                    state_d = S_LUSTALL;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_LUSTALL: state_d = S_RUN;
            default:   state_d = S_RUN;
        endcase
    end

    // ID/EX register and FSM state with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q  <= IDEX_CLEAR;
            state_q <= S_RUN;
        end else begin
            idex_q  <= idex_d;
            state_q <= state_d;
        end
    end

    assign bus.ex_valid   = idex_q.valid;
    assign bus.ex_ctrl    = idex_q.ctrl;
    assign bus.ex_rs_data = idex_q.rs_data;
    assign bus.ex_rt_data = idex_q.rt_data;
    assign bus.ex_imm     = idex_q.imm;
    assign bus.ex_rs      = idex_q.rs;
    assign bus.ex_rt      = idex_q.rt;
    assign bus.ex_dst     = idex_q.dst;
    assign bus.ex_pc4     = idex_q.pc4;
    assign bus.ex_jtarget = idex_q.jtarget;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed cases plus randomized traffic against
// a transaction-level reference model, with a scoreboard queue and an
// independent monitor on the ID/EX outputs.
module tb_decode_stage;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decode_stage_if bus();

    decode_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        ctrl_t       ctrl;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dst;
        logic [31:0] pc4;
        logic [25:0] jt;
    } exp_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sbq[$];

    // What the model believes sits in EX after the latest edge
    bit         m_valid = 1'b0;
    bit         m_mread = 1'b0;
    logic [4:0] m_dst   = 5'd0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference decode straight from the instruction set rules
    function automatic exp_t model_decode(input logic [31:0] ins, input logic [31:0] pc4,
                                          input logic [31:0] rd1, input logic [31:0] rd2,
                                          input bit wwe, input logic [4:0] wa3,
                                          input logic [31:0] wwd);
        exp_t       e;
        logic [4:0] rs, rt, rd, tgt;
        bit         wr;
        e = '0;
        rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
        wr = 1'b0; tgt = rt;
        case (ins[31:26])
            6'h00: begin
                tgt = rd;
                case (ins[5:0])
                    6'h20: begin wr = 1'b1; e.ctrl.alu_ctl = 3'b010; end
                    6'h22: begin wr = 1'b1; e.ctrl.alu_ctl = 3'b110; end
                    6'h24: begin wr = 1'b1; e.ctrl.alu_ctl = 3'b000; end
                    6'h25: begin wr = 1'b1; e.ctrl.alu_ctl = 3'b001; end
                    6'h2A: begin wr = 1'b1; e.ctrl.alu_ctl = 3'b111; end
                    default: e.ctrl.illegal = 1'b1;
                endcase
            end
            6'h23: begin wr = 1'b1; e.ctrl.mem_read = 1'b1; e.ctrl.alu_src = 1'b1; e.ctrl.alu_ctl = 3'b010; end
            6'h2B: begin e.ctrl.mem_write = 1'b1; e.ctrl.alu_src = 1'b1; e.ctrl.alu_ctl = 3'b010; end
            6'h04: begin e.ctrl.branch = 1'b1; e.ctrl.alu_ctl = 3'b110; end
            6'h08: begin wr = 1'b1; e.ctrl.alu_src = 1'b1; e.ctrl.alu_ctl = 3'b010; end
            6'h02: e.ctrl.jump = 1'b1;
            default: e.ctrl.illegal = 1'b1;
        endcase
        if (tgt == 5'd0) wr = 1'b0;
        e.ctrl.reg_write = wr;
        e.dst     = wr ? tgt : 5'd0;
        e.rs_data = rd1;
        e.rt_data = rd2;
`ifdef DECODE_WB_BYPASS_EN
        if (wwe && wa3 != 5'd0 && wa3 == rs) e.rs_data = wwd;
        if (wwe && wa3 != 5'd0 && wa3 == rt) e.rt_data = wwd;
`endif
        e.imm = {{16{ins[15]}}, ins[15:0]};
        e.rs  = rs;
        e.rt  = rt;
        e.pc4 = pc4;
        e.jt  = ins[25:0];
        return e;
    endfunction

    // One clock of stimulus; model predicts handshake and advances
    task automatic do_cycle(input bit v, input logic [31:0] ins, input logic [31:0] rd1,
                            input logic [31:0] rd2, input bit rdy, input bit fl,
                            input bit wwe, input logic [4:0] wa3, input logic [31:0] wwd);
        bit         haz, hold;
        exp_t       e;
        logic [31:0] pc4;
        @(posedge clk);
        #1;
        pc4 = $urandom;
        bus.if_valid = v;   bus.if_instr = ins; bus.if_pc4 = pc4;
        bus.rf_rd1   = rd1; bus.rf_rd2   = rd2;
        bus.ex_ready = rdy; bus.ex_flush = fl;
        bus.wb_we    = wwe; bus.wb_a3    = wa3; bus.wb_wd  = wwd;
        @(negedge clk);
        chk("ex_valid", 64'(bus.ex_valid), 64'(m_valid));
        chk("rf_a1", 64'(bus.rf_a1), 64'(ins[25:21]));
        chk("rf_a2", 64'(bus.rf_a2), 64'(ins[20:16]));
        haz  = m_valid && m_mread && (m_dst != 5'd0) &&
               ((m_dst == ins[25:21]) || (m_dst == ins[20:16]));
        hold = m_valid && !rdy;
        chk("id_ready", 64'(bus.id_ready), 64'(!hold && !haz));
        if (fl) begin
            m_valid = 1'b0;
        end else if (hold) begin
            m_valid = m_valid;
        end else if (haz) begin
            m_valid = 1'b0;
        end else if (v) begin
            e = model_decode(ins, pc4, rd1, rd2, wwe, wa3, wwd);
            sbq.push_back(e);
            m_valid = 1'b1;
            m_mread = e.ctrl.mem_read;
            m_dst   = e.dst;
        end else begin
            m_valid = 1'b0;
        end
    endtask

    task automatic idle();
        do_cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    endtask

    // Monitor: pop on each newly presented op, check stability while held
    exp_t cur;
    exp_t act;
    bit   prev_hold = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (bus.ex_valid) begin
                act = {bus.ex_ctrl, bus.ex_rs_data, bus.ex_rt_data, bus.ex_imm, bus.ex_rs,
                       bus.ex_rt, bus.ex_dst, bus.ex_pc4, bus.ex_jtarget};
                n_checks++;
                if (!prev_hold && sbq.size() == 0) begin
                    n_fail++;
                    $display("FAIL ex_unexpected: got %h expected none", act);
                end else begin
                    if (!prev_hold) cur = sbq.pop_front();
                    if (act !== cur) begin
                        n_fail++;
                        $display("FAIL ex_bundle: got %h expected %h", act, cur);
                    end
                end
            end
            prev_hold = bus.ex_valid && !bus.ex_ready && !bus.ex_flush;
        end
    end

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rs, rt, rd;
        logic [5:0]  fns [5];
        logic [31:0] w;
        fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24; fns[3] = 6'h25; fns[4] = 6'h2A;
        rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3)); rd = 5'($urandom_range(0, 3));
        w  = $urandom;
        case ($urandom_range(0, 7))
            0, 1: w = {6'h00, rs, rt, rd, 5'd0, fns[$urandom_range(0, 4)]};
            2:    w = {6'h23, rs, rt, w[15:0]};
            3:    w = {6'h2B, rs, rt, w[15:0]};
            4:    w = {6'h04, rs, rt, w[15:0]};
            5:    w = {6'h08, rs, rt, w[15:0]};
            6:    w = {6'h02, w[25:0]};
            default: w = {6'h00, rs, rt, rd, 5'd0, 6'($urandom)};
        endcase
        return w;
    endfunction

    initial begin
        bus.if_valid = 1'b1; bus.if_instr = 32'h012A4020; bus.if_pc4 = 32'h4;
        bus.rf_rd1 = 32'h5; bus.rf_rd2 = 32'h7; bus.ex_ready = 1'b1; bus.ex_flush = 1'b0;
        bus.wb_we = 1'b0; bus.wb_a3 = 5'd0; bus.wb_wd = 32'h0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ex_valid", 64'(bus.ex_valid), 64'd0);
        chk("rst_ex_ctrl", 64'(bus.ex_ctrl), 64'd0);
        chk("rst_id_ready", 64'(bus.id_ready), 64'd0);
        chk("rst_ex_rs_data", 64'(bus.ex_rs_data), 64'd0);
        chk("rst_ex_pc4", 64'(bus.ex_pc4), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.if_valid = 1'b0;
        @(negedge clk);
        chk("rel_id_ready", 64'(bus.id_ready), 64'd1);

        // add $8,$9,$10
        do_cycle(1'b1, 32'h012A4020, 32'd5, 32'd7, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("add_rf_a1", 64'(bus.rf_a1), 64'd9);
        chk("add_rf_a2", 64'(bus.rf_a2), 64'd10);
        idle();
        chk("add_dst", 64'(bus.ex_dst), 64'd8);
        chk("add_alu", 64'(bus.ex_ctrl.alu_ctl), 64'b010);
        chk("add_rs_data", 64'(bus.ex_rs_data), 64'd5);
        chk("add_rt_data", 64'(bus.ex_rt_data), 64'd7);

        // lw $8,4($9) then dependent add: one bubble
        do_cycle(1'b1, 32'h8D280004, 32'h100, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        do_cycle(1'b1, 32'h01095020, 32'h1, 32'h2, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("lu_stall_ready", 64'(bus.id_ready), 64'd0);
        do_cycle(1'b1, 32'h01095020, 32'h1, 32'h2, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("lu_bubble_valid", 64'(bus.ex_valid), 64'd0);
        chk("lu_resume_ready", 64'(bus.id_ready), 64'd1);
        idle();
        chk("lu_add_dst", 64'(bus.ex_dst), 64'd10);

        // addi $8,$0,-1 then add with dst $0
        do_cycle(1'b1, 32'h2008FFFF, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        do_cycle(1'b1, 32'h012A0020, 32'h3, 32'h4, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("addi_imm", 64'(bus.ex_imm), 64'hFFFFFFFF);
        chk("addi_alu_src", 64'(bus.ex_ctrl.alu_src), 64'd1);
        chk("addi_dst", 64'(bus.ex_dst), 64'd8);
        idle();
        chk("dst0_reg_write", 64'(bus.ex_ctrl.reg_write), 64'd0);
        chk("dst0_dst", 64'(bus.ex_dst), 64'd0);

        // Backpressure for three cycles, then flush while held
        do_cycle(1'b1, 32'h012A4020, 32'd11, 32'd12, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            do_cycle(1'b1, 32'h01495820, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
            chk("hold_id_ready", 64'(bus.id_ready), 64'd0);
            chk("hold_rs_data", 64'(bus.ex_rs_data), 64'd11);
        end
        do_cycle(1'b1, 32'h01495820, 32'd1, 32'd2, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        idle();
        chk("flush_valid", 64'(bus.ex_valid), 64'd0);

        // WB bypass on operand A, and no bypass for $0
        do_cycle(1'b1, 32'h012A4020, 32'h0, 32'd7, 1'b1, 1'b0, 1'b1, 5'd9, 32'hDEADBEEF);
        idle();
`ifdef DECODE_WB_BYPASS_EN
        chk("byp_rs_data", 64'(bus.ex_rs_data), 64'hDEADBEEF);
`else
        chk("byp_rs_data", 64'(bus.ex_rs_data), 64'h0);
`endif
        do_cycle(1'b1, 32'h000A4020, 32'h1234, 32'd7, 1'b1, 1'b0, 1'b1, 5'd0, 32'hDEADBEEF);
        idle();
        chk("byp_zero_rs_data", 64'(bus.ex_rs_data), 64'h1234);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            do_cycle(($urandom_range(0, 3) != 0), rand_instr(), $urandom, $urandom,
                     ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
                     ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 3)), $urandom);
        end

        repeat (4) idle();
        chk("sb_empty", 64'(sbq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
